// File: rtl/tt_reg_host_pkg.sv
// Shared types and constants for the tt_reg_host pin-protocol initiator.
package tt_reg_host_pkg;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WR,
        ST_RD,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } state_e;

    // Bit positions of the strobes on the tile's uio_in bus
    localparam int unsigned UIO_ALE = 0;
    localparam int unsigned UIO_WR  = 1;
    localparam int unsigned UIO_RD  = 2;

    // Width of the shared WAIT/GAP down-counter
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/tt_reg_host.sv
// Host-side initiator for the tt_um_registers pin-level register protocol.
// Turns a valid/ready command stream into one-cycle ALE/WR/RD strobes on the
// tile pins and returns one response per command (read data or write echo).
module tt_reg_host
    import tt_reg_host_pkg::*;
#(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned GAP    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_write,
    output logic [7:0] pin_ui,
    output logic [7:0] pin_uio,
    input  logic [7:0] pin_uo
);

    localparam logic [CNT_W-1:0] RD_CNT_INIT  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] GAP_CNT_INIT = (GAP == 0) ? '0 : CNT_W'(GAP - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic [7:0]         pin_ui_q, pin_ui_d;
    logic [7:0]         pin_uio_q, pin_uio_d;

    // State register plus all datapath and pin flops; async clear drops strobes at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            pin_ui_q  <= '0;
            pin_uio_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            pin_ui_q  <= pin_ui_d;
            pin_uio_q <= pin_uio_d;
        end
    end

    // Next-state logic: sequencing, shared down-counter and response capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d = ST_ADDR;
                    write_d = cmd_write;
                    wdata_d = cmd_wdata;
                end
            end
            ST_ADDR: state_d = write_q ? ST_WR : ST_RD;
            ST_WR: begin
                state_d = ST_RESP;
                rdata_d = '0;
            end
            ST_RD: begin
                state_d = ST_WAIT;
                cnt_d   = RD_CNT_INIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = pin_uo;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_CNT_INIT;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so pins and cmd_ready come straight from flops;
    // ready is a flop rather than a state decode so it stays low throughout reset
    always_comb begin
        pin_ui_d  = '0;
        pin_uio_d = '0;
        ready_d   = (state_d == ST_IDLE);
        case (state_d)
            ST_ADDR: begin
                pin_ui_d           = cmd_addr;
                pin_uio_d[UIO_ALE] = 1'b1;
            end
            ST_WR: begin
                pin_ui_d          = wdata_q;
                pin_uio_d[UIO_WR] = 1'b1;
            end
            ST_RD: begin
                pin_uio_d[UIO_RD] = 1'b1;
            end
            default: ;
        endcase
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_write = write_q;
    assign pin_ui    = pin_ui_q;
    assign pin_uio   = pin_uio_q;

endmodule

// File: tb/tb_tt_reg_host.sv
// Scoreboard bench for tt_reg_host: a register-file tile model on the pins,
// a memory-array reference model for responses, and decoupled pin/response monitors.
module tb_tt_reg_host;
    import tt_reg_host_pkg::*;

    localparam int unsigned RD_LAT = 2;
    localparam int unsigned GAP    = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       rsp_write;
    logic [7:0] pin_ui;
    logic [7:0] pin_uio;
    logic [7:0] pin_uo = 8'hFF;

    tt_reg_host #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_write (rsp_write),
        .pin_ui    (pin_ui),
        .pin_uio   (pin_uio),
        .pin_uo    (pin_uo)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] r;
        int         acc;
    } txn_t;

    int   nchecks = 0;
    int   nerrs   = 0;
    int   cyc     = 0;
    int   rsp_mode = 1;   // 0 random, 1 always ready, 2 never ready
    txn_t rsp_q[$];
    txn_t pin_q[$];
    logic [7:0] ref_mem  [256];
    logic [7:0] tile_mem [256];

    task automatic check_eq(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Tile model: latches address on ALE, stores on WR, returns data RD_LAT cycles after RD
    logic [7:0] tile_addr = '0;
    logic [7:0] rd_data   = '0;
    bit         rd_pend   = 0;
    int         rd_due    = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rd_pend && rd_due == cyc) pin_uo = rd_data;
        else                          pin_uo = 8'($urandom);
        if (rd_pend && rd_due < cyc)  rd_pend = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            rd_pend = 0;
        end else begin
            if (pin_uio[UIO_ALE]) tile_addr = pin_ui;
            if (pin_uio[UIO_WR])  tile_mem[tile_addr] = pin_ui;
            if (pin_uio[UIO_RD]) begin
                rd_pend = 1;
                rd_due  = cyc + int'(RD_LAT);
                rd_data = tile_mem[tile_addr];
            end
        end
    end

    always @(posedge clk) begin
        #2;
        case (rsp_mode)
            0:       rsp_ready = (($urandom % 4) != 0);
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'b0;
        endcase
    end

    // Pin monitor: protocol rules every cycle, strobe timing/content against issued commands
    always @(negedge clk) begin
        txn_t t;
        check_eq("proto", int'(($countones(pin_uio[2:0]) <= 1) && (pin_uio[7:3] == 5'd0)
                 && (pin_uio[2:0] != 3'd0 || pin_ui == 8'd0)), 1);
        if (pin_uio[UIO_ALE]) begin
            if (pin_q.size() == 0) begin
                check_eq("ale_unexpected", int'(pin_ui), -1);
            end else begin
                check_eq("ale_cycle", cyc, pin_q[0].acc + 1);
                check_eq("ale_addr", int'(pin_ui), int'(pin_q[0].a));
            end
        end
        if (pin_uio[UIO_WR] || pin_uio[UIO_RD]) begin
            if (pin_q.size() == 0) begin
                check_eq("strobe_unexpected", int'(pin_uio), -1);
            end else begin
                t = pin_q.pop_front();
                check_eq("strobe_cycle", cyc, t.acc + 2);
                check_eq("strobe_kind", int'(pin_uio[2:0]), t.w ? 2 : 4);
                check_eq("strobe_data", int'(pin_ui), t.w ? int'(t.d) : 0);
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response and checks hold stability
    bit         in_rsp = 0;
    logic [7:0] hold_r;
    logic       hold_w;

    always @(negedge clk) begin
        txn_t t;
        if (rsp_valid) begin
            check_eq("cmd_ready_in_resp", int'(cmd_ready), 0);
            if (!in_rsp) begin
                if (rsp_q.size() == 0) begin
                    check_eq("rsp_unexpected", int'(rsp_rdata), -1);
                end else begin
                    t = rsp_q.pop_front();
                    check_eq("rsp_latency", cyc, t.acc + 3 + (t.w ? 0 : int'(RD_LAT)));
                    check_eq("rsp_rdata", int'(rsp_rdata), int'(t.r));
                    check_eq("rsp_write", int'(rsp_write), int'(t.w));
                end
                in_rsp = 1;
                hold_r = rsp_rdata;
                hold_w = rsp_write;
            end else begin
                check_eq("rsp_hold_rdata", int'(rsp_rdata), int'(hold_r));
                check_eq("rsp_hold_write", int'(rsp_write), int'(hold_w));
            end
            if (rsp_ready) in_rsp = 0;
        end else if (in_rsp) begin
            check_eq("rsp_dropped", 0, 1);
            in_rsp = 0;
        end
    end

    // Drive one command, wait (bounded) for acceptance, record expectation in the scoreboard
    task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] d, output int acc);
        txn_t t;
        int   n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        acc = -1;
        while (acc < 0) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc;
            end else begin
                n++;
                if (n > 200) begin
                    check_eq("accept_timeout", n, 0);
                    break;
                end
            end
        end
        if (acc >= 0) begin
            t.w   = w;
            t.a   = a;
            t.d   = d;
            t.r   = w ? 8'h00 : ref_mem[a];
            t.acc = acc;
            if (w) ref_mem[a] = d;
            rsp_q.push_back(t);
            pin_q.push_back(t);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (rsp_q.size() == 0 && cmd_ready) break;
            n++;
            if (n > 300) begin
                check_eq("idle_timeout", n, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int r;
        int accs [4];
        logic [7:0] r0;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = 8'h00;
            tile_mem[i] = 8'h00;
        end

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_pin_ui", int'(pin_ui), 0);
        check_eq("rst_pin_uio", int'(pin_uio), 0);
        check_eq("rst_cmd_ready", int'(cmd_ready), 0);
        check_eq("rst_rsp_valid", int'(rsp_valid), 0);
        check_eq("rst_rsp_rdata", int'(rsp_rdata), 0);
        check_eq("rst_rsp_write", int'(rsp_write), 0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready_low", int'(cmd_ready), 0);
        @(negedge clk);
        check_eq("post_rst_ready_high", int'(cmd_ready), 1);
        @(posedge clk);
        #1;

        // Directed write, then read of freshly written data
        rsp_mode = 1;
        issue(1'b1, 8'h03, 8'h5A, acc);
        issue(1'b1, 8'h07, 8'hC3, acc);
        issue(1'b0, 8'h07, 8'h00, acc);
        wait_idle();

        // Backpressure on a read response
        rsp_mode = 2;
        issue(1'b0, 8'h03, 8'h00, acc);
        r = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                r = cyc;
                break;
            end
        end
        check_eq("bp_rsp_seen", int'(r >= 0), 1);
        r0 = rsp_rdata;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("bp_valid_held", int'(rsp_valid), 1);
            check_eq("bp_rdata_held", int'(rsp_rdata), int'(r0));
            check_eq("bp_cmd_ready_low", int'(cmd_ready), 0);
        end
        rsp_mode = 1;
        @(posedge clk);
        #1;
        issue(1'b1, 8'h20, 8'h99, acc);
        check_eq("bp_next_accept", acc, r + 5 + int'(GAP) + 1);
        wait_idle();

        // Back-to-back writes with cmd_valid held
        for (int i = 0; i < 4; i++) issue(1'b1, 8'(i), 8'($urandom), accs[i]);
        for (int i = 1; i < 4; i++) check_eq("b2b_spacing", accs[i] - accs[i-1], 4 + int'(GAP));
        wait_idle();

        // Reset in the middle of a read strobe
        issue(1'b0, 8'h07, 8'h00, acc);
        r = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pin_uio[UIO_RD]) begin
                r = cyc;
                break;
            end
        end
        check_eq("mid_rd_strobe_seen", int'(r >= 0), 1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("async_clear_uio", int'(pin_uio), 0);
        check_eq("async_clear_ui", int'(pin_ui), 0);
        rsp_q.delete();
        pin_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mid_rst_pins", int'({pin_ui, pin_uio}), 0);
            check_eq("mid_rst_rsp_valid", int'(rsp_valid), 0);
            check_eq("mid_rst_cmd_ready", int'(cmd_ready), 0);
        end
        rst = 1'b0;
        #1;
        check_eq("rel_ready_low", int'(cmd_ready), 0);
        @(negedge clk);
        check_eq("rel_ready_high", int'(cmd_ready), 1);
        check_eq("rel_no_rsp", int'(rsp_valid), 0);
        @(posedge clk);
        #1;

        // Randomized traffic with random response backpressure
        rsp_mode = 0;
        for (int i = 0; i < 80; i++) begin
            issue(1'($urandom), 8'($urandom % 16), 8'($urandom), acc);
            repeat ($urandom % 4) begin
                @(posedge clk);
                #1;
            end
        end
        rsp_mode = 1;
        wait_idle();
        check_eq("scoreboard_empty", rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule

// File: doc/tt_reg_host.md
Name: tt_reg_host

Overview:
- Host-side initiator for the pin-level register-access protocol of the tt_um_registers tile.
- Converts a valid/ready command stream (read/write, 8-bit address, 8-bit data) into registered strobes on the tile's ui_in/uio_in pins.
- For reads, captures uo_out after a fixed latency.
- Used in system benches and in FPGA bring-up harnesses that sit in front of the tile.

Parameters:
- RD_LAT, 2: clock cycles from the RD strobe cycle to the cycle in which pin_uo holds valid read data (legal 1..15).
- GAP, 1: idle cycles forced on the pins after each transaction before the next cmd accept (legal 0..7).

Ports:
- clk  in  1  single clock; everything is on posedge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  8  register address.
- cmd_wdata  in  8  write data (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_rdata  out  8  read data (0x00 for write responses).
- rsp_write  out  1  echo of cmd_write for this response.
- pin_ui  out  8  drives tile ui_in (address or data bus).
- pin_uio  out  8  drives tile uio_in: bit0 ALE (address latch), bit1 WR, bit2 RD, bits7:3 always 0.
- pin_uo  in  8  tile uo_out (read data).

Behaviour:
Reset values:
- All outputs 0 and cmd_ready=0 while rst is high.
- FSM returns to IDLE; pending command and response are discarded.
- cmd_ready rises the first cycle after rst deasserts.

Pins and handshakes:
- All pin outputs are registered.
- Strobes are exactly one cycle wide.
- Strobes are mutually exclusive.
- pin_ui=0 whenever no strobe is active.
- cmd_ready = (state==IDLE). Command fields are latched on accept.

FSM states (cycle t = accept edge):
- IDLE: on cmd_valid go to ADDR.
- ADDR (cycle t+1): pin_ui=addr, ALE=1. Next state is WR if write, RD if read.
- WR (t+2): pin_ui=wdata, WR=1. Next state is RESP; rsp_rdata=0.
- RD (t+2): RD=1, pin_ui=0. Next state is WAIT; counter loaded with RD_LAT-1.
- WAIT: count down. At counter==0, on the clock edge ending cycle t+2+RD_LAT, capture pin_uo into rsp_rdata, then go to RESP.
- RESP: rsp_valid=1 with rdata and write echo held stable. Stay until rsp_ready is sampled high, then go to GAP (or to IDLE if GAP=0).
- GAP: pins idle for GAP cycles, then go to IDLE.

Timing:
- Write: rsp_valid first high in cycle t+3.
- Read: rsp_valid first high in cycle t+3+RD_LAT.
- Zero-stall throughput (rsp_ready tied 1): one transaction per 4+GAP cycles (write) or 4+RD_LAT+GAP cycles (read).

Boundary conditions:
- cmd_valid is ignored outside IDLE; the source must hold it.
- rsp_ready=0 backpressure keeps RESP indefinitely; pins stay idle meanwhile.
- pin_uo changes outside the capture cycle do not affect rsp_rdata.
- rst mid-transaction: strobe drops immediately (async clear); no response is produced.
- Counter width is 4 bits; RD_LAT=1 means a WAIT of a single cycle.

Decomposition:
- Package tt_reg_host_pkg holds:
  - state enum (IDLE, ADDR, WR, RD, WAIT, RESP, GAP)
  - uio bit-index constants (UIO_ALE=0, UIO_WR=1, UIO_RD=2)
- No sub-module: single FSM plus one shared down-counter, used for both WAIT and GAP.

Test Plan:
1. Reset: hold rst 3 cycles mid-RD with RD_LAT=2 -> all pins 0 during reset; no rsp_valid; cmd_ready=1 one cycle after release.
2. Write 0x5A to addr 0x03 with rsp_ready=1 -> t+1 pin_ui=0x03 and pin_uio=0x01; t+2 pin_ui=0x5A and pin_uio=0x02; t+3 rsp_valid=1, rsp_write=1, rsp_rdata=0x00.
3. Read addr 0x07, RD_LAT=2, tile model drives pin_uo=0xC3 only in cycle t+4 (0xFF otherwise) -> t+2 pin_uio=0x04; rsp_valid at t+5 with rsp_rdata=0xC3.
4. Backpressure: read response with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable; cmd_ready=0 throughout; accepted on the 6th cycle; new cmd accepted GAP+1 cycles later.
5. Back-to-back: 4 writes with cmd_valid held and GAP=1 -> accepts exactly 5 cycles apart; ALE pulses carry addrs 0x00, 0x01, 0x02, 0x03 in order.
6. Protocol checker on all tests -> never more than one of uio[2:0] high; uio[7:3]==0 always; pin_ui==0 when no strobe is high.
